buffer_row_reader: RTL and testbench
====================================

Name: buffer_row_reader

Overview:
- Read-side counterpart of the input write path: consumes one completed row from the ping-pong line buffer per swap trigger.
- On each accepted swap, flips the read bank, issues sequential reads on buffer port B, and streams words out over a valid/ready interface toward the matrix serializer.
- Absorbs the RAM read latency and downstream backpressure with a credit-limited prefetch FIFO. No word is dropped or duplicated.

Parameters:
- DATA_WIDTH, 32: port-B read word width and output stream width.
- ADDRESS_NUMBER, 1024: words per bank on port B.
- ADDRESS_BITS, $clog2(ADDRESS_NUMBER): read address width.
- LEN_BITS, $clog2(ADDRESS_NUMBER+1): row length width.
- READ_LATENCY, 2: cycles from O_read_enable to valid I_read_data. Range 1..4.
- FIFO_DEPTH, 4: prefetch FIFO entries. Must be a power of 2 and ≥ READ_LATENCY+1. Elaboration fails otherwise.

Ports:
- I_clk  in  1  single clock. The swap trigger is already synchronized into this domain.
- I_rst_n  in  1  asynchronous active-low reset.
- I_swap_trigger  in  1  one-cycle pulse: the writer finished a row and swapped banks.
- I_row_length  in  LEN_BITS  words to read for the row. Sampled on the accepted swap.
- O_read_bank  out  1  bank index presented to port B.
- O_read_address  out  ADDRESS_BITS  port-B address.
- O_read_enable  out  1  port-B read strobe.
- I_read_data  in  DATA_WIDTH  port-B data, valid READ_LATENCY cycles after the strobe.
- O_data  out  DATA_WIDTH  stream data.
- O_valid  out  1  stream valid.
- I_ready  in  1  stream ready.
- O_row_start  out  1  pulse on the cycle a row is accepted.
- O_row_done  out  1  pulse on the cycle the last word of a row handshakes.
- O_busy  out  1  high from row start through row done.
- O_overrun  out  1  pulse when a swap arrives while one swap is already pending.

Behaviour:
- Reset values: all outputs 0, except O_read_bank = 1 so the first row reads bank 0. Reset also clears the FIFO, all counters and the pending flag.
- States: IDLE, READ, DRAIN.
- Swap acceptance:
  - In IDLE, I_swap_trigger starts a row next cycle: toggle O_read_bank, latch len = min(I_row_length, ADDRESS_NUMBER), set address to 0, pulse O_row_start, assert O_busy, go to READ.
  - If the latched len = 0: O_row_start and O_row_done pulse in the same cycle, no reads are issued, stay in IDLE.
- READ state:
  - Assert O_read_enable only when inflight + fifo_count < FIFO_DEPTH (credit rule).
  - Each strobe increments the address and the issued count.
  - When issued = len, go to DRAIN.
- Read-data tracking: a READ_LATENCY-deep shift register of enables pushes I_read_data into the FIFO. The credit rule guarantees the FIFO never overflows.
- Output stream:
  - O_valid = FIFO not empty. O_data = FIFO head.
  - A pop happens only on O_valid & I_ready.
  - O_data holds stable while O_valid & !I_ready.
- DRAIN state:
  - When the pop of word len-1 occurs, pulse O_row_done.
  - On that same cycle, drop O_busy unless a swap is pending.
  - Return to IDLE.
- Swap while busy:
  - Set the pending flag and latch I_row_length.
  - The pending row starts on the cycle after O_row_done, with the same actions as acceptance in IDLE.
  - A swap while pending is already set: pulse O_overrun, keep the newer length, keep one pending entry only.
- Simultaneous swap and final pop: treated as pending; the new row starts next cycle.
- Address never wraps within a row, because len ≤ ADDRESS_NUMBER.
- Throughput: 1 word/cycle sustained when I_ready is held high, after an initial latency of READ_LATENCY+1 cycles from O_row_start to first O_valid.

Decomposition:
- Shared package holds:
  - reader state enum (IDLE/READ/DRAIN);
  - function clamp_len;
  - localparam checks on FIFO_DEPTH vs READ_LATENCY.
- Sub-module sync_fifo (DATA_WIDTH, FIFO_DEPTH):
  - push/pop interface, count output, no overflow protection;
  - the reader instantiates it.

Test Plan:
- Reset, then swap with length 8, I_ready=1 → bank 0, addresses 0..7, 8 words out in address order, first O_valid 3 cycles after O_row_start, O_row_done on the 8th pop, O_busy low next cycle.
- Length 16 with I_ready toggling 1/0 every 2 cycles → all 16 words delivered in order, no duplicates, O_data stable while stalled, read strobes never exceed FIFO credit (fifo_count ≤ 4).
- Two back-to-back rows with swaps 5 cycles apart, length 10 each → second row pending, starts on the cycle after the first O_row_done, bank 1, O_overrun stays 0.
- Three swaps during one 20-word row → exactly one O_overrun pulse, second row uses the third swap's length, bank toggles only once.
- Length 0 → O_row_start and O_row_done in the same cycle, no O_read_enable. Length 2000 with ADDRESS_NUMBER=1024 → exactly 1024 reads, last address 1023.
- Assert I_rst_n low mid-row (after 5 of 12 words) → all outputs reset, O_read_bank=1. The next swap reads bank 0 from address 0.

Source files
------------

// File: rtl/buffer_row_reader_pkg.sv
// Shared types and elaboration helpers for the ping-pong buffer row reader.
package buffer_row_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } reader_state_t;

   localparam int unsigned MIN_READ_LATENCY = 1;
   localparam int unsigned MAX_READ_LATENCY = 4;

   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
      return (len > max_len) ? max_len : len;
   endfunction

   // FIFO must be a power of two and hold every word that can be in flight plus one.
   function automatic bit fifo_cfg_ok(input int unsigned depth, input int unsigned latency);
      return (latency >= MIN_READ_LATENCY) && (latency <= MAX_READ_LATENCY) &&
             (depth >= latency + 1) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/buffer_row_reader_sync_fifo.sv
// Single-clock prefetch FIFO; the caller guarantees it is never pushed while full.
module sync_fifo
   import buffer_row_reader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_BITS   = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  I_clk,
   input  logic                  I_rst_n,
   input  logic                  I_push,
   input  logic [DATA_WIDTH-1:0] I_data,
   input  logic                  I_pop,
   output logic [DATA_WIDTH-1:0] O_data,
   output logic [CNT_BITS-1:0]   O_count,
   output logic                  O_empty
);

   localparam int unsigned PTR_BITS = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_BITS-1:0]   r_wr_ptr;
   logic [PTR_BITS-1:0]   r_rd_ptr;
   logic [CNT_BITS-1:0]   r_count;

   always_ff @(posedge I_clk) begin
      if (I_push) r_mem[r_wr_ptr] <= I_data;
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (I_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (I_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         unique case ({I_push, I_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign O_data  = r_mem[r_rd_ptr];
   assign O_count = r_count;
   assign O_empty = (r_count == '0);

endmodule

// File: rtl/buffer_row_reader.sv
// Reads one completed row per swap from port B of the ping-pong line buffer and
// streams it out through a credit-limited prefetch FIFO.
module buffer_row_reader
   import buffer_row_reader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDRESS_NUMBER = 1024,
   parameter int unsigned ADDRESS_BITS   = $clog2(ADDRESS_NUMBER),
   parameter int unsigned LEN_BITS       = $clog2(ADDRESS_NUMBER + 1),
   parameter int unsigned READ_LATENCY   = 2,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input  logic                    I_clk,
   input  logic                    I_rst_n,
   input  logic                    I_swap_trigger,
   input  logic [LEN_BITS-1:0]     I_row_length,
   output logic                    O_read_bank,
   output logic [ADDRESS_BITS-1:0] O_read_address,
   output logic                    O_read_enable,
   input  logic [DATA_WIDTH-1:0]   I_read_data,
   output logic [DATA_WIDTH-1:0]   O_data,
   output logic                    O_valid,
   input  logic                    I_ready,
   output logic                    O_row_start,
   output logic                    O_row_done,
   output logic                    O_busy,
   output logic                    O_overrun
);

   localparam int unsigned CNT_BITS = $clog2(FIFO_DEPTH + 1);

   if (!fifo_cfg_ok(FIFO_DEPTH, READ_LATENCY)) begin : g_cfg_error
      $error("buffer_row_reader: FIFO_DEPTH must be a power of 2 >= READ_LATENCY+1, READ_LATENCY in 1..4");
   end

   reader_state_t           r_state;
   logic                    r_bank;
   logic                    r_busy;
   logic                    r_row_start;
   logic                    r_zero_done;
   logic                    r_overrun;
   logic                    r_pending;
   logic [LEN_BITS-1:0]     r_len;
   logic [LEN_BITS-1:0]     r_pend_len;
   logic [LEN_BITS-1:0]     r_issued;
   logic [LEN_BITS-1:0]     r_popped;
   logic [ADDRESS_BITS-1:0] r_addr;
   logic [READ_LATENCY-1:0] r_rd_pipe;

   int unsigned             w_inflight;
   logic                    w_read_en;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_empty;
   logic                    w_last_pop;
   logic                    w_start;
   logic [LEN_BITS-1:0]     w_raw_len;
   logic [LEN_BITS-1:0]     w_start_len;
   logic [LEN_BITS-1:0]     w_issued_next;
   logic [LEN_BITS-1:0]     w_popped_next;
   logic [CNT_BITS-1:0]     w_fifo_count;
   logic [DATA_WIDTH-1:0]   w_fifo_data;

   always_comb begin
      w_inflight = 0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) w_inflight += 32'(r_rd_pipe[i]);
   end

   // Credit: strobe only if every word already requested still fits in the FIFO.
   assign w_read_en     = (r_state == ST_READ) && ((w_inflight + 32'(w_fifo_count)) < FIFO_DEPTH);
   assign w_push        = r_rd_pipe[READ_LATENCY-1];
   assign w_pop         = !w_empty && I_ready;
   assign w_issued_next = r_issued + 1'b1;
   assign w_popped_next = r_popped + 1'b1;
   assign w_last_pop    = w_pop && (r_state == ST_DRAIN) && (w_popped_next == r_len);
   assign w_start       = (I_swap_trigger && (r_state == ST_IDLE)) ||
                          (w_last_pop && (r_pending || I_swap_trigger));
   // A swap landing on the final pop is newer than any pending one, so it wins.
   assign w_raw_len     = I_swap_trigger ? I_row_length : r_pend_len;
   assign w_start_len   = LEN_BITS'(clamp_len(32'(w_raw_len), ADDRESS_NUMBER));

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_state     <= ST_IDLE;
         r_bank      <= 1'b1;
         r_busy      <= 1'b0;
         r_row_start <= 1'b0;
         r_zero_done <= 1'b0;
         r_overrun   <= 1'b0;
         r_pending   <= 1'b0;
         r_len       <= '0;
         r_pend_len  <= '0;
         r_issued    <= '0;
         r_popped    <= '0;
         r_addr      <= '0;
         r_rd_pipe   <= '0;
      end else begin
         r_row_start <= 1'b0;
         r_zero_done <= 1'b0;
         r_overrun   <= I_swap_trigger && r_pending;
         r_rd_pipe   <= READ_LATENCY'({r_rd_pipe, w_read_en});
         if (w_read_en) begin
            r_addr   <= r_addr + 1'b1;
            r_issued <= w_issued_next;
            if (w_issued_next == r_len) r_state <= ST_DRAIN;
         end
         if (w_pop) r_popped <= w_popped_next;
         if (w_start) begin
            r_bank      <= ~r_bank;
            r_len       <= w_start_len;
            r_addr      <= '0;
            r_issued    <= '0;
            r_popped    <= '0;
            r_row_start <= 1'b1;
            r_pending   <= 1'b0;
            if (w_start_len == '0) begin
               r_state     <= ST_IDLE;
               r_busy      <= 1'b0;
               r_zero_done <= 1'b1;
            end else begin
               r_state <= ST_READ;
               r_busy  <= 1'b1;
            end
         end else begin
            if (w_last_pop) begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            if (I_swap_trigger && (r_state != ST_IDLE)) begin
               r_pending  <= 1'b1;
               r_pend_len <= I_row_length;
            end
         end
      end
   end

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_BITS   (CNT_BITS)
   ) u_fifo (
      .I_clk   (I_clk),
      .I_rst_n (I_rst_n),
      .I_push  (w_push),
      .I_data  (I_read_data),
      .I_pop   (w_pop),
      .O_data  (w_fifo_data),
      .O_count (w_fifo_count),
      .O_empty (w_empty)
   );

   assign O_read_bank    = r_bank;
   assign O_read_address = r_addr;
   assign O_read_enable  = w_read_en;
   assign O_valid        = !w_empty;
   assign O_data         = w_empty ? '0 : w_fifo_data;
   assign O_row_start    = r_row_start;
   assign O_row_done     = w_last_pop || r_zero_done;
   assign O_busy         = r_busy;
   assign O_overrun      = r_overrun;

endmodule

// File: tb/tb_buffer_row_reader.sv
// Directed bench: row-level model of expected words, plus hand-computed pins per scenario.
module tb_buffer_row_reader;

   logic        clk = 1'b0;
   logic        I_rst_n;
   logic        I_swap_trigger;
   logic [10:0] I_row_length;
   logic        O_read_bank;
   logic [9:0]  O_read_address;
   logic        O_read_enable;
   logic [31:0] I_read_data;
   logic [31:0] O_data;
   logic        O_valid;
   logic        I_ready;
   logic        O_row_start;
   logic        O_row_done;
   logic        O_busy;
   logic        O_overrun;

   always #5 clk = ~clk;

   buffer_row_reader #(
      .DATA_WIDTH     (32),
      .ADDRESS_NUMBER (1024),
      .READ_LATENCY   (2),
      .FIFO_DEPTH     (4)
   ) dut (
      .I_clk          (clk),
      .I_rst_n        (I_rst_n),
      .I_swap_trigger (I_swap_trigger),
      .I_row_length   (I_row_length),
      .O_read_bank    (O_read_bank),
      .O_read_address (O_read_address),
      .O_read_enable  (O_read_enable),
      .I_read_data    (I_read_data),
      .O_data         (O_data),
      .O_valid        (O_valid),
      .I_ready        (I_ready),
      .O_row_start    (O_row_start),
      .O_row_done     (O_row_done),
      .O_busy         (O_busy),
      .O_overrun      (O_overrun)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic b, input logic [9:0] a);
      return (b ? 32'h5A00_0000 : 32'hC300_0000) | {22'd0, a};
   endfunction

   // Port-B RAM: two-cycle read latency, garbage when not strobed.
   logic [31:0] ram_q0, ram_q1;
   always @(posedge clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         ram_q0 <= 32'hDEAD_BEEF;
         ram_q1 <= 32'hDEAD_BEEF;
      end else begin
         ram_q0 <= O_read_enable ? mem_word(O_read_bank, O_read_address) : 32'hDEAD_BEEF;
         ram_q1 <= ram_q0;
      end
   end
   assign I_read_data = ram_q1;

   int ready_mode = 0;
   int rcnt = 0;
   initial begin
      I_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         rcnt++;
         I_ready = (ready_mode == 0) ? 1'b1 : logic'((rcnt / 2) % 2);
      end
   end

   // Row-level model state
   int          exp_rows[$];
   logic [31:0] exp_data[$];
   logic        m_bank = 1'b1;
   logic        prev_row_bank = 1'b1;
   int          m_len = 0, m_addr = 0, words_left = 0;
   int          row_reads = 0, row_pops = 0, outstanding = 0;
   int          cyc = 0, start_cyc = 0, done_cyc = 0, start_gap = 0, first_lat = 0;
   int          last_addr = 0, first_read_addr = 0, overrun_cnt = 0;
   logic [31:0] first_data = '0, held_data = '0, w;
   logic        held_valid = 1'b0, waiting_first = 1'b0, in_row = 1'b0;
   logic        exp_done, exp_busy;

   always @(negedge clk) begin
      cyc++;
      if (!I_rst_n) begin
         check("rst_bank", 64'(O_read_bank), 64'(1));
         check("rst_read_enable", 64'(O_read_enable), 64'(0));
         check("rst_addr", 64'(O_read_address), 64'(0));
         check("rst_valid", 64'(O_valid), 64'(0));
         check("rst_data", 64'(O_data), 64'(0));
         check("rst_row_start", 64'(O_row_start), 64'(0));
         check("rst_row_done", 64'(O_row_done), 64'(0));
         check("rst_busy", 64'(O_busy), 64'(0));
         check("rst_overrun", 64'(O_overrun), 64'(0));
         exp_rows.delete();
         exp_data.delete();
         m_bank = 1'b1;
         words_left = 0;
         outstanding = 0;
         held_valid = 1'b0;
         waiting_first = 1'b0;
         in_row = 1'b0;
      end else begin
         exp_done = 1'b0;
         if (O_row_start) begin
            check("row_start_expected", 64'(exp_rows.size() != 0), 64'(1));
            m_len = (exp_rows.size() != 0) ? exp_rows.pop_front() : 0;
            prev_row_bank = m_bank;
            m_bank = ~m_bank;
            start_gap = cyc - done_cyc;
            start_cyc = cyc;
            m_addr = 0;
            row_reads = 0;
            row_pops = 0;
            words_left = m_len;
            waiting_first = (m_len > 0);
            first_read_addr = -1;
            first_data = '0;
            for (int i = 0; i < m_len; i++) exp_data.push_back(mem_word(m_bank, 10'(i)));
            if (m_len == 0) exp_done = 1'b1;
         end
         check("read_bank", 64'(O_read_bank), 64'(m_bank));
         if (O_read_enable) begin
            check("read_addr", 64'(O_read_address), 64'(m_addr));
            if (row_reads == 0) first_read_addr = int'(O_read_address);
            last_addr = int'(O_read_address);
            m_addr++;
            row_reads++;
            outstanding++;
            check("read_within_len", 64'(row_reads <= m_len), 64'(1));
            check("read_credit", 64'(outstanding <= 4), 64'(1));
         end
         if (waiting_first && O_valid) begin
            first_lat = cyc - start_cyc;
            check("first_valid_latency", 64'(first_lat), 64'(3));
            waiting_first = 1'b0;
         end
         if (held_valid) begin
            check("stall_valid", 64'(O_valid), 64'(1));
            check("stall_data", 64'(O_data), 64'(held_data));
         end
         held_valid = O_valid && !I_ready;
         held_data = O_data;
         if (O_valid && I_ready) begin
            check("pop_expected", 64'(exp_data.size() != 0), 64'(1));
            if (exp_data.size() != 0) begin
               w = exp_data.pop_front();
               check("stream_data", 64'(O_data), 64'(w));
            end
            if (row_pops == 0) first_data = O_data;
            row_pops++;
            outstanding--;
            if (words_left > 0) begin
               words_left--;
               if (words_left == 0) exp_done = 1'b1;
            end
         end
         check("row_done", 64'(O_row_done), 64'(exp_done));
         if (exp_done) done_cyc = cyc;
         exp_busy = in_row || (O_row_start && (m_len != 0));
         check("busy", 64'(O_busy), 64'(exp_busy));
         in_row = exp_busy && !exp_done;
         if (O_overrun) overrun_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic swap(input int len);
      I_swap_trigger = 1'b1;
      I_row_length = 11'(len);
      tick(1);
      I_swap_trigger = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick(1);
         if (exp_rows.size() == 0 && exp_data.size() == 0 && !in_row) begin
            ok = 1'b1;
            break;
         end
      end
      check(tag, 64'(ok), 64'(1));
      tick(2);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired actual=running required=finished");
      n_fail++;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   int ov0;
   logic ok6;

   initial begin
      I_rst_n = 1'b0;
      I_swap_trigger = 1'b0;
      I_row_length = '0;
      tick(3);
      check("reset_bank_pin", 64'(O_read_bank), 64'(1));
      check("reset_busy_pin", 64'(O_busy), 64'(0));
      I_rst_n = 1'b1;
      tick(2);

      // 8 words, ready high
      exp_rows.push_back(8);
      swap(8);
      wait_done(40, "t1_wait");
      check("t1_reads", 64'(row_reads), 64'(8));
      check("t1_last_addr", 64'(last_addr), 64'(7));
      check("t1_first_data", 64'(first_data), 64'(32'hC300_0000));
      check("t1_first_lat", 64'(first_lat), 64'(3));
      check("t1_done_offset", 64'(done_cyc - start_cyc), 64'(10));
      check("t1_busy_after", 64'(O_busy), 64'(0));

      // 16 words with ready toggling every 2 cycles
      ready_mode = 1;
      exp_rows.push_back(16);
      swap(16);
      wait_done(100, "t2_wait");
      ready_mode = 0;
      check("t2_pops", 64'(row_pops), 64'(16));
      check("t2_last_addr", 64'(last_addr), 64'(15));
      check("t2_first_data", 64'(first_data), 64'(32'h5A00_0000));
      tick(2);

      // Back-to-back rows, second swap pending
      ov0 = overrun_cnt;
      exp_rows.push_back(10);
      exp_rows.push_back(10);
      swap(10);
      tick(4);
      swap(10);
      wait_done(80, "t3_wait");
      check("t3_start_gap", 64'(start_gap), 64'(1));
      check("t3_bank1", 64'(prev_row_bank), 64'(0));
      check("t3_bank2", 64'(O_read_bank), 64'(1));
      check("t3_overrun", 64'(overrun_cnt - ov0), 64'(0));
      check("t3_pops", 64'(row_pops), 64'(10));

      // Three swaps in one 20-word row: the last length wins
      ov0 = overrun_cnt;
      exp_rows.push_back(20);
      exp_rows.push_back(9);
      swap(20);
      tick(3);
      swap(7);
      tick(2);
      swap(9);
      wait_done(100, "t4_wait");
      check("t4_overrun", 64'(overrun_cnt - ov0), 64'(1));
      check("t4_pops", 64'(row_pops), 64'(9));
      check("t4_reads", 64'(row_reads), 64'(9));
      check("t4_bank1", 64'(prev_row_bank), 64'(0));
      check("t4_bank2", 64'(O_read_bank), 64'(1));

      // Zero length, then an over-long row clamped to 1024
      exp_rows.push_back(0);
      swap(0);
      wait_done(10, "t5a_wait");
      check("t5_zero_same_cycle", 64'(done_cyc - start_cyc), 64'(0));
      check("t5_zero_reads", 64'(row_reads), 64'(0));
      exp_rows.push_back(1024);
      swap(2000);
      wait_done(1200, "t5b_wait");
      check("t5_reads", 64'(row_reads), 64'(1024));
      check("t5_last_addr", 64'(last_addr), 64'(1023));
      check("t5_pops", 64'(row_pops), 64'(1024));

      // Reset in the middle of a 12-word row
      exp_rows.push_back(12);
      swap(12);
      ok6 = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (row_pops >= 5) begin
            ok6 = 1'b1;
            break;
         end
      end
      check("t6_reach_5", 64'(ok6), 64'(1));
      I_rst_n = 1'b0;
      #1;
      check("t6_rst_bank", 64'(O_read_bank), 64'(1));
      check("t6_rst_valid", 64'(O_valid), 64'(0));
      check("t6_rst_busy", 64'(O_busy), 64'(0));
      tick(2);
      I_rst_n = 1'b1;
      tick(2);
      exp_rows.push_back(4);
      swap(4);
      wait_done(40, "t6_wait");
      check("t6_first_addr", 64'(first_read_addr), 64'(0));
      check("t6_bank", 64'(O_read_bank), 64'(0));
      check("t6_first_data", 64'(first_data), 64'(32'hC300_0000));
      check("t6_pops", 64'(row_pops), 64'(4));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
